// File: rtl/load_use_scoreboard_if.sv
// Hazard-unit bundle: ID-stage sources, EX-stage load info and the resulting stall/bubble/pending.
// The pipeline side uses the master modport; the hazard unit uses slave.
interface load_use_scoreboard_if #(
    parameter int NREGS = 32
);
    localparam int REG_W = $clog2(NREGS);

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             flush;
    logic             stall;
    logic             bubble;
    logic [NREGS-1:0] pending;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_mem_read, ex_rd, flush,
        input  stall, bubble, pending
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_mem_read, ex_rd, flush,
        output stall, bubble, pending
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: EX-stage compare plus per-register countdown for older loads.
// Optional macro HAZARD_STATS_EN adds saturating stall_cycles / hazard_events counters.
module load_use_scoreboard #(
    parameter  int NREGS    = 32,
    parameter  int LOAD_LAT = 1,
    localparam int REG_W    = $clog2(NREGS),
    localparam int CNT_W    = $clog2(LOAD_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    load_use_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           hazard_events
`endif
);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             ex_load;
    logic             ex_hit;
    logic             sb_hit;
    logic             stall_int;

    always_comb begin
        ex_load = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0);
        ex_hit  = ex_load & ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                             (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
        // cnt_q[0] never leaves zero, so x0 sources fall out naturally.
        sb_hit  = (bus.id_rs1_used & (cnt_q[bus.id_rs1] != '0)) |
                  (bus.id_rs2_used & (cnt_q[bus.id_rs2] != '0));
        stall_int = rst & ~bus.flush & (ex_hit | sb_hit);
    end

    assign bus.stall  = stall_int;
    assign bus.bubble = stall_int;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if ((LOAD_LAT > 1) && ex_load && (bus.ex_rd == REG_W'(r))) begin
                // A newer load always carries the largest remaining latency.
                cnt_d[r] = CNT_W'(LOAD_LAT - 1);
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!rst) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            bus.pending[r] = rst & ((cnt_q[r] != '0) | (ex_load & (bus.ex_rd == REG_W'(r))));
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] hazard_events_q;
    logic [31:0] hazard_events_d;
    logic        stall_prev_q;
    logic        stall_prev_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        hazard_events_d = hazard_events_q;
        stall_prev_d    = stall_int;
        if (stall_int && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        // An episode starts on the first stalled cycle after a non-stalled one.
        if (stall_int && !stall_prev_q && (hazard_events_q != '1)) begin
            hazard_events_d = hazard_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q  <= '0;
            hazard_events_q <= '0;
            stall_prev_q    <= 1'b0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            hazard_events_q <= hazard_events_d;
            stall_prev_q    <= stall_prev_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign hazard_events = hazard_events_q;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard: three instances (LOAD_LAT 1,2,3) share one stimulus stream
// and are compared against a ready-time reference model, a vector table and directed sequences.
module tb_load_use_scoreboard;

    localparam int NREGS = 32;
    localparam int NL    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       flush = 1'b0;

    logic             stall_w   [NL];
    logic             bubble_w  [NL];
    logic [NREGS-1:0] pending_w [NL];
`ifdef HAZARD_STATS_EN
    logic [31:0]      cycles_w  [NL];
    logic [31:0]      events_w  [NL];
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        load_use_scoreboard_if #(.NREGS(NREGS)) bus ();
        assign bus.id_rs1      = id_rs1;
        assign bus.id_rs2      = id_rs2;
        assign bus.id_rs1_used = id_rs1_used;
        assign bus.id_rs2_used = id_rs2_used;
        assign bus.ex_valid    = ex_valid;
        assign bus.ex_mem_read = ex_mem_read;
        assign bus.ex_rd       = ex_rd;
        assign bus.flush       = flush;
        assign stall_w[g]      = bus.stall;
        assign bubble_w[g]     = bus.bubble;
        assign pending_w[g]    = bus.pending;
`ifdef HAZARD_STATS_EN
        load_use_scoreboard #(.NREGS(NREGS), .LOAD_LAT(g + 1)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .bus           (bus),
            .stall_cycles  (cycles_w[g]),
            .hazard_events (events_w[g])
        );
`else
        load_use_scoreboard #(.NREGS(NREGS), .LOAD_LAT(g + 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
`endif
    end

    // Reference model: a load issued at cycle t makes rd readable at cycle t+LOAD_LAT.
    int now = 0;
    int ready [NL][NREGS];
    int m_cycles [NL];
    int m_events [NL];
    bit m_prev [NL];
    bit m_stall_now [NL];

    function automatic bit m_ex_load();
        return ex_valid && ex_mem_read && (ex_rd != 0);
    endfunction

    function automatic bit m_pend(int l, int r);
        if (r == 0 || !rst) return 1'b0;
        return (ready[l][r] > now) || (m_ex_load() && (int'(ex_rd) == r));
    endfunction

    function automatic bit m_stall(int l);
        if (!rst || flush) return 1'b0;
        return (id_rs1_used && m_pend(l, int'(id_rs1))) ||
               (id_rs2_used && m_pend(l, int'(id_rs2)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] ep;
        for (int l = 0; l < NL; l++) begin
            ep = '0;
            for (int r = 0; r < NREGS; r++) ep[r] = m_pend(l, r);
            chk($sformatf("stall L%0d", l + 1), 32'(stall_w[l]), 32'(m_stall(l)));
            chk($sformatf("bubble L%0d", l + 1), 32'(bubble_w[l]), 32'(m_stall(l)));
            chk($sformatf("pending L%0d", l + 1), pending_w[l], ep);
`ifdef HAZARD_STATS_EN
            chk($sformatf("stall_cycles L%0d", l + 1), cycles_w[l], 32'(m_cycles[l]));
            chk($sformatf("hazard_events L%0d", l + 1), events_w[l], 32'(m_events[l]));
`endif
        end
    endtask

    // Advance one clock edge and the model with it; inputs are stable until then.
    task automatic tick();
        for (int l = 0; l < NL; l++) m_stall_now[l] = m_stall(l);
        @(posedge clk);
        for (int l = 0; l < NL; l++) begin
            if (!rst) begin
                for (int r = 0; r < NREGS; r++) ready[l][r] = 0;
                m_cycles[l] = 0;
                m_events[l] = 0;
                m_prev[l]   = 1'b0;
            end else begin
                if (m_stall_now[l]) m_cycles[l]++;
                if (m_stall_now[l] && !m_prev[l]) m_events[l]++;
                m_prev[l] = m_stall_now[l];
                if (m_ex_load()) ready[l][ex_rd] = now + l + 1;
            end
        end
        now++;
        #1;
    endtask

    task automatic set_id(logic [4:0] r1, logic u1, logic [4:0] r2, logic u2);
        id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    endtask

    task automatic set_ex(logic v, logic mr, logic [4:0] rd);
        ex_valid = v; ex_mem_read = mr; ex_rd = rd;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        @(negedge clk); check_model(); tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        exv;
        logic        exmr;
        logic [4:0]  exrd;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t tbl [9];
    int   scnt [NL];
    int   expn;

    initial begin
        // rs1 u1 rs2 u2 exv exmr exrd fl | stall pending
        tbl[0] = '{5'd1,  1, 5'd0,  0, 1, 1, 5'd1,  0, 1, 32'h0000_0002};
        tbl[1] = '{5'd0,  0, 5'd1,  1, 1, 1, 5'd1,  0, 1, 32'h0000_0002};
        tbl[2] = '{5'd1,  0, 5'd2,  1, 1, 1, 5'd1,  0, 0, 32'h0000_0002};
        tbl[3] = '{5'd1,  1, 5'd0,  0, 1, 0, 5'd1,  0, 0, 32'h0000_0000};
        tbl[4] = '{5'd1,  1, 5'd0,  0, 0, 1, 5'd1,  0, 0, 32'h0000_0000};
        tbl[5] = '{5'd0,  1, 5'd0,  1, 1, 1, 5'd0,  0, 0, 32'h0000_0000};
        tbl[6] = '{5'd1,  1, 5'd4,  1, 1, 1, 5'd5,  0, 0, 32'h0000_0020};
        tbl[7] = '{5'd1,  1, 5'd0,  0, 1, 1, 5'd1,  1, 0, 32'h0000_0002};
        tbl[8] = '{5'd3,  1, 5'd31, 1, 1, 1, 5'd31, 0, 1, 32'h8000_0000};

        for (int l = 0; l < NL; l++) begin
            for (int r = 0; r < NREGS; r++) ready[l][r] = 0;
            m_cycles[l] = 0; m_events[l] = 0; m_prev[l] = 1'b0;
        end
        @(posedge clk); #1;
        do_reset();
        do_reset();

        // Single-cycle vectors from an empty scoreboard.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_id(tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2);
            set_ex(tbl[i].exv, tbl[i].exmr, tbl[i].exrd);
            flush = tbl[i].fl;
            @(negedge clk);
            check_model();
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("tbl%0d stall L%0d", i, l + 1), 32'(stall_w[l]), 32'(tbl[i].exp_stall));
                chk($sformatf("tbl%0d pending L%0d", i, l + 1), pending_w[l], tbl[i].exp_pend);
            end
            tick();
            flush = 1'b0;
        end

        // lw x1 ; k independent instructions ; add x3,x1,x4 -> max(0, LAT-k) stall cycles.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int l = 0; l < NL; l++) scnt[l] = 0;
            for (int c = 0; c < k + 6; c++) begin
                if (c == 0) set_ex(1'b1, 1'b1, 5'd1);
                else        set_ex(1'b1, 1'b0, 5'd0);
                if (c < k)  set_id(5'd0, 1'b0, 5'd0, 1'b0);
                else        set_id(5'd1, 1'b1, 5'd4, 1'b1);
                @(negedge clk);
                check_model();
                for (int l = 0; l < NL; l++) scnt[l] += int'(stall_w[l]);
                tick();
            end
            for (int l = 0; l < NL; l++) begin
                expn = (l + 1 - k > 0) ? (l + 1 - k) : 0;
                chk($sformatf("gap%0d stall count L%0d", k, l + 1), 32'(scnt[l]), 32'(expn));
            end
        end

        // Flush in the first stall cycle: no stall, older load still drains.
        do_reset();
        set_ex(1'b1, 1'b1, 5'd1); set_id(5'd1, 1'b1, 5'd4, 1'b1); flush = 1'b1;
        @(negedge clk); check_model();
        for (int l = 0; l < NL; l++) chk($sformatf("flush stall L%0d", l + 1), 32'(stall_w[l]), 32'd0);
        tick();
        flush = 1'b0; set_ex(1'b0, 1'b0, 5'd0); set_id(5'd6, 1'b1, 5'd7, 1'b1);
        @(negedge clk); check_model();
        chk("flush pend1 L2 c1", 32'(pending_w[1][1]), 32'd1);
        chk("flush pend1 L1 c1", 32'(pending_w[0][1]), 32'd0);
        tick();
        @(negedge clk); check_model();
        chk("flush pend1 L2 c2", 32'(pending_w[1][1]), 32'd0);
        chk("flush pend1 L3 c2", 32'(pending_w[2][1]), 32'd1);
        tick();

        // Reset while the LAT=3 counter for x1 sits at 2.
        do_reset();
        set_ex(1'b1, 1'b1, 5'd1); set_id(5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); check_model(); tick();
        rst = 1'b0; set_ex(1'b0, 1'b0, 5'd0); set_id(5'd1, 1'b1, 5'd1, 1'b1);
        @(negedge clk); check_model();
        chk("rst hold pend L3", pending_w[2], 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk); check_model();
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("post-rst stall L%0d", l + 1), 32'(stall_w[l]), 32'd0);
            chk($sformatf("post-rst pending L%0d", l + 1), pending_w[l], 32'd0);
        end
        tick();

        // Random traffic on a small register set to force collisions.
        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 59) != 0);
            flush = ($urandom_range(0, 7) == 0);
            set_id(5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 4)));
            @(negedge clk);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Parametrised load-use hazard unit for the 5-stage femtoRV32 pipeline, generalising the fixed single-cycle ID/EX load-use check to a configurable load-to-use latency and register-file size. Sits beside the ID stage: it compares ID-stage source registers against the load in EX plus a per-register countdown scoreboard of older in-flight loads. It drives the PC/IF_ID hold and the ID_EX bubble.

## Interface
- NREGS, 32: architectural registers (32 for RV32I, 16 for RV32E); power of two.
- REG_W, $clog2(NREGS): register index width; derived, do not override.
- LOAD_LAT, 1: stall cycles a dependent instruction in ID needs when its producing load is in EX; legal range 1..4.
- CNT_W, $clog2(LOAD_LAT+1): scoreboard counter width; derived.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs1  in  REG_W  rs1 of instruction in IF_ID.
- id_rs2  in  REG_W  rs2 of instruction in IF_ID.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- ex_valid  in  1  ID_EX holds a live instruction (not a bubble).
- ex_mem_read  in  1  ID_EX MemRead control bit.
- ex_rd  in  REG_W  ID_EX destination register.
- flush  in  1  branch/jump redirect; kills the instruction in IF_ID this cycle.
- stall  out  1  hold PC and IF_ID.
- bubble  out  1  zero the ID_EX control word next edge; always equals stall.
- pending  out  NREGS  bit i = register i has a load result not yet forwardable (debug).
- stall_cycles  out  32  only with HAZARD_STATS_EN: cycles with stall=1.
- hazard_events  out  32  only with HAZARD_STATS_EN: stall episodes (rising edges of stall).

## Operation
- Load issue: ex_load = ex_valid & ex_mem_read & (ex_rd != 0).
- Remaining latency of a load: LOAD_LAT in the cycle it is in EX, decrementing by 1 per cycle after that. A register is hazardous while its remaining latency is ≥ 1.
- EX term (combinational): ex_load and ex_rd matches a used ID source.
- Scoreboard: cnt[r] for r in 1..NREGS-1; cnt[0] is hard-wired 0. Each edge:
  - If ex_load and LOAD_LAT > 1: cnt[ex_rd] <= LOAD_LAT-1.
  - Otherwise: every nonzero cnt decrements by 1.
  - Newer load to the same rd overwrites the older value. This is always the maximum, so no compare is needed.
- Scoreboard term: cnt[id_rsX] != 0 for a used source.
- With LOAD_LAT=1 the counters are never loaded and synthesise away. Behaviour matches the classic one-bubble check.
- stall = rst & ~flush & (EX term | scoreboard term). flush wins: a dead ID instruction never stalls.
- A bubble inserted by stall makes ex_valid=0 next cycle, so the same load is never double-counted.
- x0 as a source never stalls; x0 as a destination is never tracked.
- pending[r] = (cnt[r] != 0) | (ex_load & ex_rd == r).

## Timing
- Reset (rst=0 at an edge): all cnt = 0, stall_cycles = 0, hazard_events = 0. stall, bubble and pending are forced 0 while rst=0.
- Reset mid-operation clears the scoreboard with no residual stalls.
- stall is combinational from the ID/EX inputs and cnt registers, valid in the same cycle.
- Consumer immediately behind a load stalls exactly LOAD_LAT cycles.
- Consumer with k independent instructions between stalls max(0, LOAD_LAT-k) cycles.
- Flush during a stall: stall drops that cycle, and the scoreboard keeps counting for the older load.
- Counters: 32-bit, saturate at 2^32-1 (no wrap).

## Configuration
- HAZARD_STATS_EN defined: the stall_cycles and hazard_events ports exist and count as specified.
- Undefined: both ports are absent and the counter logic is removed. Hazard behaviour is identical either way.

## Test plan
- LOAD_LAT=1: lw x1,0(x2); add x3,x1,x4. Expect stall=1 for exactly 1 cycle while add is in ID, bubble in ID_EX, then add proceeds; hazard_events=1, stall_cycles=1.
- LOAD_LAT=3, same pair: stall high 3 consecutive cycles; pending[1]=1 for 3 cycles then 0.
- LOAD_LAT=3: lw x1; nop; add x3,x1,x4. Expect a 2-cycle stall. With two nops, a 1-cycle stall.
- lw x0,0(x2); add x3,x0,x0, and lw x5; add x3,x1,x4 (unrelated). Expect stall=0 throughout for both.
- LOAD_LAT=2: lw x1 then a dependent add, with flush asserted in the first stall cycle. Expect stall=0 that cycle; cnt[1] continues to 0 next cycle.
- Assert rst=0 while cnt[1]=2; release. Expect pending=0, stall=0, and stat counters 0.
